// File: rtl/pio_cmd_loader.sv
// pio_cmd_loader: assembles PIO commands from a byte stream.
// Frame: header {mindex, action}, index, din[7:0] .. din[31:24].
// A zero byte while idle is a sync byte and is skipped. A frame that
// stalls for TIMEOUT idle clocks is dropped and flagged on frame_err.
// Optional feature: define PIO_CMD_LOADER_CHECKSUM_EN to append a 7th
// byte holding the XOR of the first six; a mismatch drops the frame.
module pio_cmd_loader #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [5:0]  action,
  output logic [31:0] din,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    GAP     = 2'd3
  } state_t;

`ifdef PIO_CMD_LOADER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_r;
  logic [2:0]  byte_cnt_r;
  logic [15:0] tmo_cnt_r;
  logic [7:0]  hdr_r;
  logic [4:0]  idx_r;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
  logic [31:0] data_r;
  logic [7:0]  csum_r;
  logic        csum_ok_s;
`else
  logic [23:0] data_r;
`endif

  logic        accept_s;
  logic [31:0] issue_din_s;

  assign accept_s = rx_valid & rx_ready;

  // Data word presented at issue: without a checksum the last data byte is
  // taken straight from the bus in the same cycle it is accepted.
  always_comb begin
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
    issue_din_s = data_r;
    csum_ok_s   = (csum_r == rx_data);
`else
    issue_din_s = {rx_data, data_r};
`endif
  end

  // Frame FSM with registered handshake, command outputs and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rx_ready   <= 1'b1;
      byte_cnt_r <= 3'd0;
      tmo_cnt_r  <= 16'd0;
      hdr_r      <= 8'h00;
      idx_r      <= 5'd0;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
      data_r     <= 32'h0000_0000;
      csum_r     <= 8'h00;
`else
      data_r     <= 24'h00_0000;
`endif
      action     <= 6'd0;
      din        <= 32'h0000_0000;
      index      <= 5'd0;
      mindex     <= 2'd0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      // Strobes and the action code are single-cycle by default.
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      action    <= 6'd0;
      case (state_r)
        IDLE: begin
          tmo_cnt_r <= 16'd0;
          if (accept_s && (rx_data != 8'h00)) begin
            hdr_r      <= rx_data;
            byte_cnt_r <= 3'd1;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
            csum_r     <= rx_data;
`endif
            state_r    <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept_s) begin
            tmo_cnt_r  <= 16'd0;
            byte_cnt_r <= byte_cnt_r + 3'd1;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
            csum_r     <= csum_r ^ rx_data;
`endif
            case (byte_cnt_r)
              3'd1: idx_r <= rx_data[4:0];
              3'd2: data_r[7:0]   <= rx_data;
              3'd3: data_r[15:8]  <= rx_data;
              3'd4: data_r[23:16] <= rx_data;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
              3'd5: data_r[31:24] <= rx_data;
`endif
              default: ;
            endcase
            if (byte_cnt_r == LAST_IDX) begin
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
              if (csum_ok_s) begin
                state_r   <= ISSUE;
                rx_ready  <= 1'b0;
                action    <= hdr_r[5:0];
                mindex    <= hdr_r[7:6];
                index     <= idx_r;
                din       <= issue_din_s;
                cmd_valid <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
              end else begin
                state_r   <= IDLE;
                frame_err <= 1'b1;
              end
`else
              state_r   <= ISSUE;
              rx_ready  <= 1'b0;
              action    <= hdr_r[5:0];
              mindex    <= hdr_r[7:6];
              index     <= idx_r;
              din       <= issue_din_s;
              cmd_valid <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
`endif
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            // Stalled frame: discard it, leave command outputs untouched.
            state_r   <= IDLE;
            frame_err <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end
        ISSUE: begin
          state_r <= GAP;
        end
        GAP: begin
          state_r  <= IDLE;
          rx_ready <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_loader.sv
// Scoreboard bench for pio_cmd_loader: a byte-stream reference model
// pushes expected commands/errors; a negedge monitor pops and compares.
module tb_pio_cmd_loader;

  localparam int TMO = 10;
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [5:0]  action;
  logic [31:0] din;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic        cmd_valid;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  pio_cmd_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .action(action), .din(din), .index(index),
    .mindex(mindex), .cmd_valid(cmd_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [5:0]  action;
    logic [1:0]  mindex;
    logic [4:0]  index;
    logic [31:0] din;
    logic [7:0]  fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_cmd  = 0;

  // reference model state: a frame is just a list of collected bytes
  bit         m_in_frame = 1'b0;
  logic [7:0] m_buf[7];
  int         m_len = 0;
  logic [7:0] m_fcnt = 8'd0;

  // last issued values as seen by the monitor
  logic [31:0] l_din = 32'd0;
  logic [4:0]  l_index = 5'd0;
  logic [1:0]  l_mindex = 2'd0;
  logic [7:0]  l_fcnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.action = 6'd0; e.mindex = 2'd0; e.index = 5'd0;
    e.din = 32'd0; e.fcnt = m_fcnt;
    exp_q.push_back(e);
  endtask

  // a gap of idle cycles before the next byte; long gaps kill an open frame
  task automatic model_gap(input int gap);
    if (m_in_frame && gap >= TMO) begin
      push_err();
      m_in_frame = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    logic [7:0] x;
    if (!m_in_frame) begin
      if (b != 8'h00) begin
        m_buf[0] = b; m_len = 1; m_in_frame = 1'b1;
      end
    end else begin
      m_buf[m_len] = b;
      m_len++;
      if (m_len == FLEN) begin
        m_in_frame = 1'b0;
        x = 8'h00;
        for (int i = 0; i < 6; i++) x = x ^ m_buf[i];
        if (FLEN == 7 && x != m_buf[6]) begin
          push_err();
        end else begin
          m_fcnt = m_fcnt + 8'd1;
          e.is_err = 1'b0;
          e.action = m_buf[0][5:0];
          e.mindex = m_buf[0][7:6];
          e.index  = m_buf[1][4:0];
          e.din    = {m_buf[5], m_buf[4], m_buf[3], m_buf[2]};
          e.fcnt   = m_fcnt;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int tries;
    model_gap(gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b;
    rx_valid = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
      tries++;
    end
    if (acc) model_byte(b);
    else begin
      errors++; checks++;
      $display("FAIL accept_stall: byte %h not accepted within 50 cycles", b);
    end
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 13) return 0;
    else if (r < 17) return $urandom_range(1, 3);
    else if (r == 17) return TMO - 1;
    else if (r == 18) return TMO;
    else return TMO + 3;
  endfunction

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] idx,
                            input logic [31:0] d, input int g0,
                            input bit rnd_gaps, input bit corrupt);
    logic [7:0] b[7];
    b[0] = hdr; b[1] = idx;
    b[2] = d[7:0]; b[3] = d[15:8]; b[4] = d[23:16]; b[5] = d[31:24];
    b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ (corrupt ? 8'h01 : 8'h00);
    for (int i = 0; i < FLEN; i++)
      send_byte(b[i], (i == 0) ? g0 : (rnd_gaps ? rand_gap() : 0));
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0; m_len = 0; m_fcnt = 8'd0;
    exp_q.delete();
    l_din = 32'd0; l_index = 5'd0; l_mindex = 2'd0; l_fcnt = 8'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_action"}, action, 32'd0);
    check({tag, "_din"}, din, 32'd0);
    check({tag, "_index"}, index, 32'd0);
    check({tag, "_mindex"}, mindex, 32'd0);
    check({tag, "_cmd_valid"}, cmd_valid, 32'd0);
    check({tag, "_frame_err"}, frame_err, 32'd0);
    check({tag, "_frame_cnt"}, frame_cnt, 32'd0);
  endtask

  // monitor: pops the scoreboard on every strobe, checks holds otherwise
  initial begin
    bit prev_cmd, prev_err;
    exp_t e;
    prev_cmd = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_cmd = 1'b0; prev_err = 1'b0;
      end else begin
        if (prev_cmd) begin
          check("gap_action", action, 32'd0);
          check("gap_cmd_valid", cmd_valid, 32'd0);
        end
        if (prev_err) check("err_single_pulse", frame_err, 32'd0);
        if (cmd_valid || frame_err) begin
          if (cmd_valid) n_cmd++;
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_strobe: cmd_valid=%b frame_err=%b, expected none", cmd_valid, frame_err);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {cmd_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
            if (!e.is_err) begin
              check("cmd_action", action, e.action);
              check("cmd_mindex", mindex, e.mindex);
              check("cmd_index", index, e.index);
              check("cmd_din", din, e.din);
              check("cmd_frame_cnt", frame_cnt, e.fcnt);
              check("issue_rx_ready", rx_ready, 32'd0);
              l_din = e.din; l_index = e.index; l_mindex = e.mindex; l_fcnt = e.fcnt;
            end else begin
              check("err_action", action, 32'd0);
              check("err_frame_cnt", frame_cnt, e.fcnt);
            end
          end
        end else begin
          check("hold_action", action, 32'd0);
          check("hold_din", din, l_din);
          check("hold_index", index, l_index);
          check("hold_mindex", mindex, l_mindex);
          check("hold_frame_cnt", frame_cnt, l_fcnt);
        end
        prev_cmd = cmd_valid; prev_err = frame_err;
      end
    end
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #1 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    check("reset_rx_ready", rx_ready, 32'd1);

    // basic frame
    send_frame(8'h41, 8'h03, 32'h1234_5678, 0, 1'b0, 1'b0);
    idle(4);
    check("f1_din", din, 32'h1234_5678);
    check("f1_index", index, 32'd3);
    check("f1_mindex", mindex, 32'd1);
    check("f1_frame_cnt", frame_cnt, 32'd1);

    // sync bytes then the same frame; index byte with upper bits set
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_frame(8'h41, 8'hE3, 32'h1234_5678, 0, 1'b0, 1'b0);
    idle(3);

    // timeout after two bytes, then a valid frame
    send_byte(8'h41, 0);
    send_byte(8'h03, 0);
    send_frame(8'h41, 8'h03, 32'hCAFE_F00D, 20, 1'b0, 1'b0);
    idle(3);

    // timeout boundary: TMO-1 idle cycles survive, TMO idle cycles expire
    send_byte(8'h85, 0);
    send_byte(8'h07, TMO - 1);
    send_byte(8'hAA, 0); send_byte(8'hBB, TMO - 1);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
`ifdef PIO_CMD_LOADER_CHECKSUM_EN
    send_byte(8'h85 ^ 8'h07 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
    send_byte(8'h85, 3);
    send_byte(8'h07, TMO);
    idle(3);

`ifdef PIO_CMD_LOADER_CHECKSUM_EN
    send_frame(8'h41, 8'h03, 32'h1234_5678, 0, 1'b0, 1'b0);
    send_frame(8'h41, 8'h03, 32'h1234_5678, 0, 1'b0, 1'b1);
    idle(3);
`endif

    // reset after the third byte of a frame
    send_byte(8'h62, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    model_reset();
    rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_rx_ready", rx_ready, 32'd1);
    idle(20);

    // 256 back-to-back frames with rx_valid held high
    n0 = n_cmd;
    for (int f = 0; f < 256; f++)
      send_frame({2'($urandom), 6'($urandom_range(1, 63))}, 8'($urandom),
                 $urandom, 0, 1'b0, 1'b0);
    idle(4);
    check("b2b_strobes", n_cmd - n0, 32'd256);
    check("b2b_frame_cnt_wrap", frame_cnt, 32'd0);

    // randomized stream with sync bytes, random gaps and timeouts
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'h00, $urandom_range(0, 2));
      send_frame({2'($urandom), 6'($urandom_range(1, 63))}, 8'($urandom),
                 $urandom, rand_gap(), 1'b1, ($urandom_range(0, 5) == 0));
    end

    // flush any open frame and drain
    model_gap(TMO + 20);
    idle(TMO + 20);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
